fifo_sync_param: RTL
====================

Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO, next generation of the team's 8-deep FIFO DUT. It generalises width and depth and supports non-power-of-two depths. It adds:
- programmable almost-full/almost-empty levels
- an occupancy count output
- a synchronous flush
- an optional first-word-fall-through (FWFT) read mode

It sits between a producer and a consumer in one clock domain. It is the DUT for the next UVM/SVA environment.

Parameters:
- FIFO_WIDTH, 16: data word width in bits, ≥1.
- FIFO_DEPTH, 8: number of storage entries, ≥2, any integer.
- FWFT, 0: read mode. 0 = standard (data_out registered one cycle after the read). 1 = head word shown on data_out while not empty.
- CNT_W, $clog2(FIFO_DEPTH+1): width of count and the level ports (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents; has priority over wr_en/rd_en.
- data_in  in  FIFO_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request (standard mode) or pop (FWFT).
- af_level  in  CNT_W  almost-full threshold (count ≥ af_level).
- ae_level  in  CNT_W  almost-empty threshold (count ≤ ae_level).
- data_out  out  FIFO_WIDTH  read data.
- wr_ack  out  1  registered; previous-cycle write accepted.
- overflow  out  1  registered; previous-cycle write rejected because full.
- underflow  out  1  registered; previous-cycle read rejected because empty.
- count  out  CNT_W  current occupancy, 0..FIFO_DEPTH.
- full, empty, almostfull, almostempty, half_full  out  1  combinational from count.

Behaviour:
- Reset (rst_n=0, asynchronous): pointers, count, data_out, wr_ack, overflow and underflow go to 0. Resulting flags: empty=1, full=0, half_full=0. Storage array is not reset.
- Acceptance is decided from full/empty as sampled at the start of the cycle:
  - write accepted iff wr_en & !full
  - read accepted iff rd_en & !empty
- Simultaneous wr_en & rd_en:
  - not full and not empty: both accepted, count unchanged.
  - empty: write accepted, read rejected, underflow=1.
  - full: read accepted, write rejected, overflow=1.
- wr_ack / overflow / underflow are valid for exactly one cycle after the request. They are 0 when the corresponding enable is 0.
- Pointers wrap from FIFO_DEPTH-1 to 0. Explicit wrap compare; no reliance on power-of-two overflow.
- count is +1 on write only, −1 on read only, unchanged on both or neither. It never leaves 0..FIFO_DEPTH.
- Flags:
  - full = (count==FIFO_DEPTH)
  - empty = (count==0)
  - half_full = (count ≥ ceil(FIFO_DEPTH/2))
  - almostfull = (count ≥ af_level) & !full
  - almostempty = (count ≤ ae_level) & !empty
  - Levels are sampled live, not latched.
- Standard mode (FWFT=0): on an accepted read, data_out ← mem[rd_ptr] at that edge (latency 1). data_out holds its value otherwise.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] whenever !empty, 0 when empty. rd_en pops the head; the next word appears the same cycle the pointer advances. Write-to-visible latency when empty is 1 cycle.
- Flush:
  - Next edge: pointers and count go to 0, wr_ack=0, overflow=0, underflow=0.
  - Any concurrent wr/rd is ignored; no ack/err is raised for it.
  - data_out is unchanged in mode 0.
- Reset asserted mid-transfer wins immediately. No partial write is retained in count.

Decomposition:
- FIFO_pkg gains:
  - defaults FIFO_WIDTH and FIFO_DEPTH
  - a cnt_t typedef helper
  - a fifo_status_t packed struct {full, empty, almostfull, almostempty, half_full}
- One sub-module, fifo_ptr_ctrl: pointer and count update with wrap and accept logic.
- Storage array and output muxing stay in fifo_sync_param.

Test Plan:
- DEPTH=8, reset then write 0x0001..0x0008 → wr_ack each cycle. count steps 1..8; half_full from count=4; full at 8. A 9th write gives overflow=1, wr_ack=0.
- Full FIFO, FWFT=0: 8 reads → data_out 0x0001..0x0008, each one cycle after rd_en. empty at count 0. A 9th read gives underflow=1 and data_out holds 0x0008.
- count=4 with wr_en & rd_en for 10 cycles → count stays 4, in-order data, no errors. Repeat at empty (only write accepted, underflow=1) and at full (only read accepted, overflow=1).
- FIFO_DEPTH=6, 20 alternating write/read bursts → pointers wrap at 5→0, no data corruption, full at count 6.
- af_level=5, ae_level=2: fill 0→8 → almostempty for count 1..2, almostfull for 5..7, deasserted at 8. Changing af_level to 3 at count=4 raises almostfull next cycle.
- Flush at count 5 with concurrent wr_en → count=0 and empty next cycle, wr_ack=0. Async rst_n pulse mid-write → outputs zero immediately, before the next edge.
- FWFT=1: single write of 0xABCD to an empty FIFO → data_out=0xABCD one cycle later without rd_en; rd_en then gives empty=1 and data_out=0.

Source files
------------

// File: rtl/fifo_sync_param_pkg.sv
// fifo_sync_param_pkg: shared defaults, count type and status flags for fifo_sync_param
package fifo_sync_param_pkg;
  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(FIFO_DEPTH_DEF + 1);
  typedef logic [CNT_W_DEF-1:0] cnt_t;
  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
    logic half_full;
  } fifo_status_t;
  function automatic int half_level(input int depth);
    return (depth + 1) / 2;
  endfunction
endpackage

// File: rtl/fifo_sync_param_ptr_ctrl.sv
// fifo_ptr_ctrl: accept decisions, wrapping pointers, occupancy count and handshake flags
module fifo_ptr_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic             wr_acc,
  output logic             rd_acc,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             wr_ack,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  logic full, empty;
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      wr_ack <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= flush ? '0 : wr_acc ? (wr_ptr == LAST ? '0 : wr_ptr + PTR_W'(1)) : wr_ptr;
      rd_ptr <= flush ? '0 : rd_acc ? (rd_ptr == LAST ? '0 : rd_ptr + PTR_W'(1)) : rd_ptr;
      count <= flush ? '0 : count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      wr_ack <= wr_acc;
      overflow <= wr_en & full & ~flush;
      underflow <= rd_en & empty & ~flush;
    end
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with levels, count, flush and optional FWFT
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int FWFT = 0,
  parameter int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      af_level,
  input  logic [CNT_W-1:0]      ae_level,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  half_full
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  fifo_status_t st;
  fifo_ptr_ctrl #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .PTR_W(PTR_W)) u_ctrl (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .wr_acc(wr_acc),
    .rd_acc(rd_acc),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .count(count),
    .wr_ack(wr_ack),
    .overflow(overflow),
    .underflow(underflow)
  );
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= data_in;
  always_comb begin
    st.full = count == CNT_W'(FIFO_DEPTH);
    st.empty = count == '0;
    st.half_full = count >= CNT_W'(half_level(FIFO_DEPTH));
    st.almostfull = (count >= af_level) & ~st.full;
    st.almostempty = (count <= ae_level) & ~st.empty;
  end
  assign {full, empty, almostfull, almostempty, half_full} = st;
  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = st.empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) data_out <= '0;
        else if (rd_acc) data_out <= mem[rd_ptr];
    end
  endgenerate
endmodule
